multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS-lite datapath: addu, subu, ori, lw, sw, beq, lui, jal, jr, nop.
- Replaces single-cycle decode with a FETCH/DECODE/EXE/MEM/WB state machine that shares one unified memory port between instruction fetch and data access.
- Holds the current step, drives datapath enables and muxes per state, handshakes with memory, and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. 0 = reset asserted.
- op  in  6  IR[31:26], from the datapath instruction register.
- func  in  6  IR[5:0].
- zero  in  1  ALU equality flag (rs == rt).
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- IRWrite  out  1  load IR from memory read data.
- PCWrite  out  1  load PC from NPC mux.
- npcsel  out  2  00 PC+4, 01 branch target, 10 jal target, 11 GPR[rs].
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- ALUSrc  out  1  0 GPR[rt], 1 extended immediate.
- MemtoReg  out  2  00 ALU result, 01 memory data, 10 PC (already +4).
- RegWrite  out  1  GPR write enable.
- MemWrite  out  1  store qualifier on mem_req.
- EXTop  out  2  00 zero-extend, 01 sign-extend, 10 lui (imm<<16).
- ALUctr  out  2  00 add, 01 sub, 10 or.
- state  out  3  FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal  out  1  one-cycle pulse in DECODE for an undefined op/func.
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

Behaviour:
- Reset low, async: state=FETCH, instr_count=0. While reset is low, every output is 0.
- state and instr_count are registered. All other outputs are combinational from state, op, func, zero and mem_ready.
- op and func are only meaningful from DECODE onward. FETCH outputs ignore them.
- FETCH:
  - mem_req=1, MemWrite=0.
  - Hold until mem_ready=1.
  - On the mem_ready cycle: IRWrite=1, PCWrite=1, npcsel=00, next state DECODE.
- DECODE, by instruction:
  - nop or jr: next FETCH, instr_done=1. jr also drives PCWrite=1, npcsel=11.
  - jal: next WB.
  - Undefined: illegal=1, instr_done=1, next FETCH (treated as nop).
  - All others: next EXE.
- EXE, ALU controls held stable for the whole state:
  - addu: ALUctr=00, ALUSrc=0. subu: ALUctr=01, ALUSrc=0.
  - ori: ALUctr=10, ALUSrc=1, EXTop=00.
  - lui: ALUctr=00, ALUSrc=1, EXTop=10.
  - lw, sw: ALUctr=00, ALUSrc=1, EXTop=01, next MEM.
  - beq: ALUctr=01, ALUSrc=0, EXTop=01. PCWrite=zero, npcsel=01, instr_done=1, next FETCH.
  - Other ALU ops: next WB.
- MEM:
  - mem_req=1, MemWrite=1 for sw. Hold until mem_ready.
  - On mem_ready: sw sets instr_done=1, next FETCH; lw goes to WB.
  - ALU controls stay as in EXE so the address is stable.
- WB: RegWrite=1 for exactly one cycle, instr_done=1, next FETCH.
  - addu/subu: RegDst=01, MemtoReg=00.
  - ori/lui: RegDst=00, MemtoReg=00.
  - lw: RegDst=00, MemtoReg=01.
  - jal: RegDst=10, MemtoReg=10, plus PCWrite=1, npcsel=10 in the same cycle.
- instr_count increments on every clk edge where instr_done=1, including illegal instructions.
- Fixed latencies with zero memory wait:
  - nop, jr: 2 cycles.
  - beq, jal: 3 cycles.
  - ALU ops, sw: 4 cycles.
  - lw: 5 cycles.
  - Each memory wait cycle adds 1.
- Default for any output not listed in a state is 0. mem_req is never asserted outside FETCH/MEM.
- A reset asserted mid-instruction aborts it with no count increment. The first cycle after release is FETCH.
- Unreachable state encodings (5-7) go to FETCH on the next edge with all outputs 0.

Test Plan:
- Reset low 3 cycles, then high; mem_ready=1; IR=addu (op 000000, func 100001) -> states 0,1,2,4. WB shows RegWrite=1, RegDst=01. instr_count=1.
- lw (op 100011); mem_ready low for 2 cycles in MEM -> MEM held 3 cycles with mem_req=1, MemWrite=0. WB shows MemtoReg=01. Total 7 cycles.
- beq with zero=1 then with zero=0 -> EXE shows PCWrite=1 then 0, npcsel=01 in both. Each takes 3 cycles.
- jal (op 000011) -> WB shows RegDst=10, MemtoReg=10, PCWrite=1, npcsel=10. jr -> DECODE shows PCWrite=1, npcsel=11, 2 cycles total.
- op=111111 -> illegal pulse in DECODE, count increments, back to FETCH. Reset dropped during a MEM wait -> all outputs 0 immediately, state=0, instr_count=0.
- Preload instr_count=2^CNT_W-1 (force), retire a nop -> instr_count=0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the MIPS-lite
// datapath plus the shared memory port.
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] npcsel;
    logic [1:0] RegDst;
    logic       ALUSrc;
    logic [1:0] MemtoReg;
    logic       RegWrite;
    logic       MemWrite;
    logic [1:0] EXTop;
    logic [1:0] ALUctr;

    modport master (
        input  op, func, zero, mem_ready,
        output mem_req, IRWrite, PCWrite, npcsel, RegDst, ALUSrc,
               MemtoReg, RegWrite, MemWrite, EXTop, ALUctr
    );

    modport slave (
        output op, func, zero, mem_ready,
        input  mem_req, IRWrite, PCWrite, npcsel, RegDst, ALUSrc,
               MemtoReg, RegWrite, MemWrite, EXTop, ALUctr
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXE/MEM/WB sequencer for the MIPS-lite datapath,
// sharing one memory port between instruction fetch and data access.
//
// state  | meaning
// FETCH  | request instruction word, load IR and PC+4 on mem_ready
// DECODE | classify IR; nop/jr/illegal retire here, jal skips to WB
// EXE    | ALU operation; beq resolves and retires here
// MEM    | data access for lw/sw, held until mem_ready
// WB     | register file write, jal also redirects PC
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus,
    output logic [2:0]         state,
    output logic               instr_done,
    output logic               illegal,
    output logic [CNT_W-1:0]   instr_count
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXE    = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic is_rtype, is_addu, is_subu, is_jr, is_nop;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_jal, is_legal;

    always_comb begin
        is_rtype = (bus.op == 6'b000000);
        is_addu  = is_rtype && (bus.func == 6'b100001);
        is_subu  = is_rtype && (bus.func == 6'b100011);
        is_jr    = is_rtype && (bus.func == 6'b001000);
        is_nop   = is_rtype && (bus.func == 6'b000000);
        is_ori   = (bus.op == 6'b001101);
        is_lui   = (bus.op == 6'b001111);
        is_lw    = (bus.op == 6'b100011);
        is_sw    = (bus.op == 6'b101011);
        is_beq   = (bus.op == 6'b000100);
        is_jal   = (bus.op == 6'b000011);
        is_legal = is_addu | is_subu | is_jr | is_nop | is_ori | is_lui |
                   is_lw | is_sw | is_beq | is_jal;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_nop || is_jr || !is_legal) state_d = S_FETCH;
                else if (is_jal)                  state_d = S_WB;
                else                              state_d = S_EXE;
            end
            S_EXE: begin
                if (is_lw || is_sw) state_d = S_MEM;
                else if (is_beq)    state_d = S_FETCH;
                else                state_d = S_WB;
            end
            S_MEM: begin
                if (!bus.mem_ready) state_d = S_MEM;
                else if (is_sw)     state_d = S_FETCH;
                else                state_d = S_WB;
            end
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Everything is forced low while reset is held, including the FETCH request.
    always_comb begin
        bus.mem_req  = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.npcsel   = 2'b00;
        bus.RegDst   = 2'b00;
        bus.ALUSrc   = 1'b0;
        bus.MemtoReg = 2'b00;
        bus.RegWrite = 1'b0;
        bus.MemWrite = 1'b0;
        bus.EXTop    = 2'b00;
        bus.ALUctr   = 2'b00;
        instr_done   = 1'b0;
        illegal      = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        bus.IRWrite = 1'b1;
                        bus.PCWrite = 1'b1;
                    end
                end
                S_DECODE: begin
                    if (is_jr) begin
                        bus.PCWrite = 1'b1;
                        bus.npcsel  = 2'b11;
                    end
                    if (is_nop || is_jr || !is_legal) instr_done = 1'b1;
                    if (!is_legal) illegal = 1'b1;
                end
                S_EXE, S_MEM: begin
                    // MEM keeps the EXE ALU controls so the data address holds.
                    if (is_subu) bus.ALUctr = 2'b01;
                    if (is_ori) begin
                        bus.ALUctr = 2'b10;
                        bus.ALUSrc = 1'b1;
                    end
                    if (is_lui) begin
                        bus.ALUSrc = 1'b1;
                        bus.EXTop  = 2'b10;
                    end
                    if (is_lw || is_sw) begin
                        bus.ALUSrc = 1'b1;
                        bus.EXTop  = 2'b01;
                    end
                    if (is_beq) begin
                        bus.ALUctr = 2'b01;
                        bus.EXTop  = 2'b01;
                    end
                    if (state_q == S_EXE && is_beq) begin
                        bus.PCWrite = bus.zero;
                        bus.npcsel  = 2'b01;
                        instr_done  = 1'b1;
                    end
                    if (state_q == S_MEM) begin
                        bus.mem_req  = 1'b1;
                        bus.MemWrite = is_sw;
                        if (bus.mem_ready && is_sw) instr_done = 1'b1;
                    end
                end
                S_WB: begin
                    bus.RegWrite = 1'b1;
                    instr_done   = 1'b1;
                    if (is_addu || is_subu) bus.RegDst = 2'b01;
                    if (is_lw) bus.MemtoReg = 2'b01;
                    if (is_jal) begin
                        bus.RegDst   = 2'b10;
                        bus.MemtoReg = 2'b10;
                        bus.PCWrite  = 1'b1;
                        bus.npcsel   = 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        count_d = count_q + CNT_W'(instr_done);
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule
